exu_stage: RTL and testbench
============================

Name: exu_stage

Overview:
- Handshaked execute stage of the NPC core, sitting between IDU and WBU/LSU.
- Takes decoded operands, a register destination and an op code.
- Computes the ALU result, using a multi-cycle iterative multiplier for MUL.
- Holds the result in an output register until the downstream stage accepts it.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two, at least 8.
- REG_ADDR_WIDTH, 5, register-file address width.
- OP_WIDTH, 4, op-code width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream has a valid instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_op  input  OP_WIDTH  operation select.
- in_src1  input  DATA_WIDTH  operand A.
- in_src2  input  DATA_WIDTH  operand B (register).
- in_imm  input  DATA_WIDTH  immediate, already sign-extended.
- in_use_imm  input  1  1: operand B = in_imm; 0: operand B = in_src2.
- in_rd  input  REG_ADDR_WIDTH  destination register.
- out_valid  output  1  result registered and valid.
- out_ready  input  1  downstream accepts the result.
- out_wen  output  1  register-file write enable.
- out_waddr  output  REG_ADDR_WIDTH  register-file write address.
- out_wdata  output  DATA_WIDTH  result.
- busy  output  1  high while in MUL state.

Behaviour:
- Reset values: state IDLE; out_valid, out_wen, busy, out_waddr, out_wdata all 0.
- Reset wins over every other event, including an in-flight MUL or a held result. The result is discarded.
- Handshakes:
  - Accept occurs when in_valid and in_ready are both high.
  - Result transfer occurs when out_valid and out_ready are both high.
- in_ready = (state==IDLE) or (state==DONE and out_ready). This gives back-to-back throughput of 1 for single-cycle ops.
- Operand B = in_use_imm ? in_imm : in_src2. Operands, op and rd are latched on accept.
- Shift amount = low log2(DATA_WIDTH) bits of B.
- Op codes:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL
  - 6 SRL
  - 7 SRA (arithmetic)
  - 8 SLT (signed, result 0/1)
  - 9 SLTU (result 0/1)
  - 10 MUL (low DATA_WIDTH bits of product)
  - 11–15 illegal: result 0, out_wen forced 0.
- All arithmetic is modulo 2^DATA_WIDTH; no overflow flags.
- out_wen = 1 only for a legal op with rd != 0.
- FSM states IDLE, MUL, DONE:
  - IDLE, accept of a non-MUL op: go to DONE next edge with result loaded. Latency 1 cycle.
  - IDLE, accept of MUL: go to MUL. Shift-add loop: one multiplier bit per cycle, exactly DATA_WIDTH cycles. Then go to DONE. Latency DATA_WIDTH+1 cycles from accept to out_valid.
  - MUL: in_ready=0, busy=1. out_ready is ignored.
  - DONE: out_valid=1. out_wen, out_waddr and out_wdata stay stable until transfer.
    - Transfer with no new accept: go to IDLE.
    - Transfer with a simultaneous accept: go to DONE (non-MUL, new result loaded) or MUL.
- out_valid deasserts the cycle after a transfer unless a new single-cycle result was loaded in the same edge.
- MUL with operand 0 still takes the full DATA_WIDTH cycles (fixed latency).

Optional Feature:
- Macro: EXU_FAST_MUL_EN.
- Defined: MUL is computed combinationally in one cycle and behaves like any other single-cycle op (latency 1). The MUL state is unreachable and busy stays 0.
- Undefined: iterative multiplier as above, latency DATA_WIDTH+1.

Test Plan:
- Reset then ADD: src1=5, imm=7, use_imm=1, rd=3 -> out_valid next cycle, wdata=12, waddr=3, wen=1.
- Back-to-back with out_ready=1: ADD then SUB, src1=1, src2=2 -> consecutive out_valid cycles; wdata 3 then 0xFFFFFFFF; in_ready stays 1.
- Backpressure: hold out_ready=0 for 5 cycles after a SLT of -1 vs 1 -> wdata=1 held stable, in_ready=0; released after out_ready=1.
- MUL 0x10000 × 0x10001 (macro off) -> busy for 32 cycles, out_valid at cycle 33, wdata=0x00010000. With the macro on -> out_valid at cycle 1.
- rd=0 with ADD, and op=12 with rd=4 -> wen=0 in both cases; illegal op gives wdata=0.
- Assert rst at cycle 10 of a MUL -> next cycle IDLE, out_valid=0, busy=0, in_ready=1; no result emitted.

Source files
------------

// File: rtl/exu_stage.sv
// rtl/exu_stage.sv - handshaked execute stage: ALU, iterative shift-add MUL, held result register
// Optional EXU_FAST_MUL_EN: single-cycle combinational MUL instead of the DATA_WIDTH-cycle loop.
module exu_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_WIDTH-1:0]       in_op,
    input  logic [DATA_WIDTH-1:0]     in_src1,
    input  logic [DATA_WIDTH-1:0]     in_src2,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic                      in_use_imm,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_wen,
    output logic [REG_ADDR_WIDTH-1:0] out_waddr,
    output logic [DATA_WIDTH-1:0]     out_wdata,
    output logic                      busy
);

    localparam int SH_W = $clog2(DATA_WIDTH);

`ifdef EXU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(10);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0]     opb;
    logic [SH_W-1:0]           shamt;
    logic [DATA_WIDTH-1:0]     alu_res;
    logic                      op_legal;
    logic                      accept;
    logic                      is_mul_iter;

    logic [DATA_WIDTH-1:0]     mul_acc;
    logic [DATA_WIDTH-1:0]     mul_mcand;
    logic [DATA_WIDTH-1:0]     mul_mplier;
    logic [DATA_WIDTH-1:0]     mul_sum;
    logic [SH_W-1:0]           mul_cnt;
    logic                      mul_last;
    logic [REG_ADDR_WIDTH-1:0] mul_rd;

    assign opb         = in_use_imm ? in_imm : in_src2;
    assign shamt       = opb[SH_W-1:0];
    assign op_legal    = (in_op <= OP_MUL);
    assign in_ready    = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept      = in_valid && in_ready;
    assign is_mul_iter = !FAST_MUL && (in_op == OP_MUL);
    assign out_valid   = (state == DONE);
    assign busy        = (state == MUL);

    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = in_src1 + opb;
            OP_SUB:  alu_res = in_src1 - opb;
            OP_AND:  alu_res = in_src1 & opb;
            OP_OR:   alu_res = in_src1 | opb;
            OP_XOR:  alu_res = in_src1 ^ opb;
            OP_SLL:  alu_res = in_src1 << shamt;
            OP_SRL:  alu_res = in_src1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(in_src1) >>> shamt);
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_src1) < $signed(opb))};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (in_src1 < opb)};
            OP_MUL:  alu_res = FAST_MUL ? (in_src1 * opb) : '0;
            default: alu_res = '0;
        endcase
    end

    // One multiplier bit per cycle; the final bit is folded into the result load.
    assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_last = (mul_cnt == SH_W'(DATA_WIDTH-1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = is_mul_iter ? MUL : DONE;
            MUL:  if (mul_last) state_next = DONE;
            DONE: if (out_ready) begin
                      if (in_valid) state_next = is_mul_iter ? MUL : DONE;
                      else          state_next = IDLE;
                  end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_wen    <= 1'b0;
            out_waddr  <= '0;
            out_wdata  <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            mul_rd     <= '0;
        end else begin
            if (accept) begin
                if (is_mul_iter) begin
                    mul_acc    <= '0;
                    mul_mcand  <= opb;
                    mul_mplier <= in_src1;
                    mul_cnt    <= '0;
                    mul_rd     <= in_rd;
                end else begin
                    out_wdata <= alu_res;
                    out_waddr <= in_rd;
                    out_wen   <= op_legal && (in_rd != '0);
                end
            end
            if (state == MUL) begin
                mul_acc    <= mul_sum;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + 1'b1;
                if (mul_last) begin
                    out_wdata <= mul_sum;
                    out_waddr <= mul_rd;
                    out_wen   <= (mul_rd != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_exu_stage.sv
// tb/tb_exu_stage.sv - directed table-driven bench for exu_stage
module tb_exu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic        out_wen;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_wen(out_wen),
        .out_waddr(out_waddr), .out_wdata(out_wdata), .busy(busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic        wen;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
        in_valid   = 1'b1;
        in_op      = op;
        in_src1    = a;
        in_src2    = b;
        in_imm     = imm;
        in_use_imm = use_imm;
        in_rd      = rd;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp, input string tag);
        int n;
        int busy_cnt;
        @(negedge clk);
        out_ready = 1'b1;
        drive(4'd10, a, b, 32'h0, 1'b0, rd);
        n = 0;
        busy_cnt = 0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            if (busy && !in_ready) busy_cnt++;
            @(negedge clk);
            n++;
        end
`ifdef EXU_FAST_MUL_EN
        chk({tag, "_latency"}, n, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, 0);
`else
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_busy_cycles"}, busy_cnt, 32);
`endif
        chk({tag, "_wdata"}, out_wdata, exp);
        chk({tag, "_waddr"}, {27'd0, out_waddr}, {27'd0, rd});
        chk({tag, "_wen"}, {31'd0, out_wen}, 32'd1);
        @(negedge clk);
        chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  32'd5,          32'd0,          32'd7, 1'b1, 5'd3, 32'd12,         1'b1};
        vecs[1]  = '{4'd0,  32'd1,          32'd2,          32'd0, 1'b0, 5'd1, 32'd3,          1'b1};
        vecs[2]  = '{4'd1,  32'd1,          32'd2,          32'd0, 1'b0, 5'd2, 32'hFFFFFFFF,   1'b1};
        vecs[3]  = '{4'd2,  32'h0000F0F0,   32'h00000FF0,   32'd0, 1'b0, 5'd4, 32'h000000F0,   1'b1};
        vecs[4]  = '{4'd3,  32'h0000F0F0,   32'h00000FF0,   32'd0, 1'b0, 5'd5, 32'h0000FFF0,   1'b1};
        vecs[5]  = '{4'd4,  32'h0000F0F0,   32'h00000FF0,   32'd0, 1'b0, 5'd6, 32'h0000FF00,   1'b1};
        vecs[6]  = '{4'd5,  32'd1,          32'h0000003F,   32'd0, 1'b0, 5'd7, 32'h80000000,   1'b1};
        vecs[7]  = '{4'd6,  32'h80000000,   32'd0,          32'd4, 1'b1, 5'd8, 32'h08000000,   1'b1};
        vecs[8]  = '{4'd7,  32'h80000000,   32'd0,          32'd4, 1'b1, 5'd9, 32'hF8000000,   1'b1};
        vecs[9]  = '{4'd8,  32'hFFFFFFFF,   32'd1,          32'd0, 1'b0, 5'd10, 32'd1,         1'b1};
        vecs[10] = '{4'd9,  32'hFFFFFFFF,   32'd1,          32'd0, 1'b0, 5'd11, 32'd0,         1'b1};
        vecs[11] = '{4'd0,  32'd1,          32'd2,          32'd0, 1'b0, 5'd0, 32'd3,          1'b0};
        vecs[12] = '{4'd12, 32'd1,          32'd2,          32'd0, 1'b0, 5'd4, 32'd0,          1'b0};
        vecs[13] = '{4'd0,  32'hFFFFFFFF,   32'd1,          32'd0, 1'b0, 5'd12, 32'd0,         1'b1};

        rst = 1'b1;
        out_ready = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_wen", {31'd0, out_wen}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_waddr", {27'd0, out_waddr}, 32'd0);
        chk("rst_wdata", out_wdata, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back single-cycle ops with out_ready held high.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].use_imm, vecs[i].rd);
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_wdata", i), out_wdata, vecs[i].exp);
            chk($sformatf("v%0d_waddr", i), {27'd0, out_waddr}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_wen", i), {31'd0, out_wen}, {31'd0, vecs[i].wen});
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: SLT -1 < 1 held for 5 cycles.
        out_ready = 1'b0;
        drive(4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd5);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_wdata", k), out_wdata, 32'd1);
            chk($sformatf("bp%0d_waddr", k), {27'd0, out_waddr}, 32'd5);
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        run_mul(32'h00010000, 32'h00010001, 5'd7, 32'h00010000, "mul_a");
        run_mul(32'd0, 32'h12345678, 5'd8, 32'd0, "mul_zero");
        run_mul(32'h00000007, 32'hFFFFFFFF, 5'd9, 32'hFFFFFFF9, "mul_neg");

        // Reset in the middle of a MUL discards it.
        drive(4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 5'd6);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_wdata", out_wdata, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (out_valid || busy) seen++;
            end
            chk("mrst_no_result", seen, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
